// File: rtl/lcd_split_pkg.sv
// Shared types and constants for the split-record LCD writer.
// Holds the sequencer state encoding, LCD command and character codes,
// step-index landmarks and the BCD-to-ASCII helpers used by the step ROM.
package lcd_split_pkg;

    // Sequencer states; ST_BOOT is the single post-reset cycle that launches init
    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SEND   = 3'd3,
        ST_SETTLE = 3'd4,
        ST_NEXT   = 3'd5
    } lcd_state_e;

    // LCD controller commands
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;

    // Character codes
    localparam logic [7:0] CHR_COLON      = 8'h3A;
    localparam logic [7:0] CHR_DOT        = 8'h2E;
    localparam logic [7:0] CHR_SPACE      = 8'h20;
    localparam logic [7:0] CHR_DASH       = 8'h2D;
    localparam logic [7:0] CHR_DIGIT_BASE = 8'h30;

    // Register-select values
    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_CHAR = 1'b1;

    // Step-index landmarks
    localparam logic [5:0] INIT_FIRST  = 6'd0;
    localparam logic [5:0] INIT_STEPS  = 6'd4;
    localparam logic [5:0] FRAME_FIRST = 6'd4;
    localparam logic [5:0] LAST_STEP   = 6'd37;

    // One BCD nibble to its ASCII digit; out-of-range nibbles show as a dash
    function automatic logic [7:0] bcd_char(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib > 4'd9) begin
            ch = CHR_DASH;
        end else begin
            ch = CHR_DIGIT_BASE | {4'h0, nib};
        end
        return ch;
    endfunction

    // Character at position pos (0..6) of one "MM:SS.t" field
    function automatic logic [7:0] field_char(input logic [19:0] rec,
                                              input logic [5:0]  pos);
        logic [7:0] ch;
        case (pos)
            6'd0:    ch = bcd_char(rec[19:16]);
            6'd1:    ch = bcd_char(rec[15:12]);
            6'd2:    ch = CHR_COLON;
            6'd3:    ch = bcd_char(rec[11:8]);
            6'd4:    ch = bcd_char(rec[7:4]);
            6'd5:    ch = CHR_DOT;
            6'd6:    ch = bcd_char(rec[3:0]);
            default: ch = CHR_DASH;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/lcd_step_rom.sv
// Step ROM: maps a step index plus the 80-bit record snapshot to the
// {RS, DATA} pair that the writer sends for that step. Purely combinational.
module lcd_step_rom
    import lcd_split_pkg::*;
(
    input  logic [5:0]  step_idx,
    input  logic [79:0] snap,
    output logic [8:0]  step_word
);

    // Decode index into init command, line address, spacer or field character
    always_comb begin
        step_word = {RS_CMD, 8'h00};
        case (step_idx) inside
            6'd0:           step_word = {RS_CMD, CMD_FUNC_SET};
            6'd1:           step_word = {RS_CMD, CMD_DISP_ON};
            6'd2:           step_word = {RS_CMD, CMD_HOME};
            6'd3:           step_word = {RS_CMD, CMD_ENTRY};
            6'd4:           step_word = {RS_CMD, CMD_LINE1};
            [6'd5:6'd11]:   step_word = {RS_CHAR, field_char(snap[19:0],  step_idx - 6'd5)};
            6'd12, 6'd13:   step_word = {RS_CHAR, CHR_SPACE};
            [6'd14:6'd20]:  step_word = {RS_CHAR, field_char(snap[39:20], step_idx - 6'd14)};
            6'd21:          step_word = {RS_CMD, CMD_LINE2};
            [6'd22:6'd28]:  step_word = {RS_CHAR, field_char(snap[59:40], step_idx - 6'd22)};
            6'd29, 6'd30:   step_word = {RS_CHAR, CHR_SPACE};
            [6'd31:6'd37]:  step_word = {RS_CHAR, field_char(snap[79:60], step_idx - 6'd31)};
            default:        step_word = {RS_CMD, 8'h00};
        endcase
    end

endmodule

// File: rtl/lcd_split_writer.sv
// Split-record LCD writer: runs the LCD init sequence once after reset and
// then redraws a two-line frame of four "MM:SS.t" fields on each update
// request, one byte per start/done handshake followed by a settle delay.
module lcd_split_writer
    import lcd_split_pkg::*;
#(
    parameter int SETTLE_CYCLES = 262143
) (
    input  logic        iCLK,
    input  logic        reset,
    input  logic [79:0] iRecords,
    input  logic        iUpdate,
    output logic        oBusy,
    output logic        oFrameDone,
    output logic [7:0]  oLCD_DATA,
    output logic        oLCD_RS,
    output logic        oLCD_Start,
    input  logic        iLCD_Done
);

    // Counter holds 0..SETTLE_CYCLES-1, so it never needs to wrap
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : CNT_W'(1'b0);

    lcd_state_e       state_r, state_next_s;
    logic [5:0]       idx_r, idx_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             pend_r, pend_next_s;
    logic [79:0]      snap_r, snap_next_s;
    logic             active_s;
    logic [8:0]       rom_word_s;

    logic [7:0]       data_r, data_next_s;
    logic             rs_r, rs_next_s;
    logic             start_r, start_next_s;
    logic             busy_r, busy_next_s;
    logic             fdone_r, fdone_next_s;

    // ROM is addressed with the upcoming index/snapshot so the byte is ready on entry to LOAD
    lcd_step_rom u_rom (
        .step_idx  (idx_next_s),
        .snap      (snap_next_s),
        .step_word (rom_word_s)
    );

    // State, index, settle counter, pending flag and snapshot registers
    always_ff @(posedge iCLK) begin
        if (reset) begin
            state_r <= ST_BOOT;
            idx_r   <= 6'd0;
            cnt_r   <= '0;
            pend_r  <= 1'b0;
            snap_r  <= 80'd0;
        end else begin
            state_r <= state_next_s;
            idx_r   <= idx_next_s;
            cnt_r   <= cnt_next_s;
            pend_r  <= pend_next_s;
            snap_r  <= snap_next_s;
        end
    end

    // Next-state logic: step sequencing, handshake, settle timing and request merging
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        cnt_next_s   = cnt_r;
        snap_next_s  = snap_r;
        active_s     = (state_r != ST_IDLE) && (state_r != ST_BOOT);
        // Requests arriving mid-sequence collapse into a single pending redraw
        pend_next_s  = pend_r | (iUpdate & active_s);
        case (state_r)
            ST_BOOT: begin
                state_next_s = ST_LOAD;
                idx_next_s   = INIT_FIRST;
                snap_next_s  = iRecords;
                pend_next_s  = 1'b0;
            end
            ST_IDLE: begin
                if (iUpdate || pend_r) begin
                    state_next_s = ST_LOAD;
                    idx_next_s   = FRAME_FIRST;
                    snap_next_s  = iRecords;
                    pend_next_s  = 1'b0;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_SEND;
            end
            ST_SEND: begin
                if (iLCD_Done) begin
                    cnt_next_s = '0;
                    if (SETTLE_CYCLES == 0) begin
                        state_next_s = ST_NEXT;
                    end else begin
                        state_next_s = ST_SETTLE;
                    end
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_NEXT;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1'b1);
                end
            end
            ST_NEXT: begin
                if (idx_r < LAST_STEP) begin
                    idx_next_s   = idx_r + 6'd1;
                    state_next_s = ST_LOAD;
                end else if (pend_r || iUpdate) begin
                    idx_next_s   = FRAME_FIRST;
                    snap_next_s  = iRecords;
                    pend_next_s  = 1'b0;
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_BOOT;
            end
        endcase
    end

    // Output decode: values the output registers take on the coming edge
    always_comb begin
        data_next_s  = data_r;
        rs_next_s    = rs_r;
        if (state_next_s == ST_LOAD) begin
            rs_next_s   = rom_word_s[8];
            data_next_s = rom_word_s[7:0];
        end else begin
            rs_next_s   = rs_r;
            data_next_s = data_r;
        end
        start_next_s = (state_next_s == ST_SEND);
        busy_next_s  = (state_next_s != ST_IDLE) && (state_next_s != ST_BOOT);
        fdone_next_s = (state_r == ST_NEXT) && (idx_r == LAST_STEP);
    end

    // Registered LCD byte interface and status outputs
    always_ff @(posedge iCLK) begin
        if (reset) begin
            data_r  <= 8'h00;
            rs_r    <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            fdone_r <= 1'b0;
        end else begin
            data_r  <= data_next_s;
            rs_r    <= rs_next_s;
            start_r <= start_next_s;
            busy_r  <= busy_next_s;
            fdone_r <= fdone_next_s;
        end
    end

    assign oLCD_DATA  = data_r;
    assign oLCD_RS    = rs_r;
    assign oLCD_Start = start_r;
    assign oBusy      = busy_r;
    assign oFrameDone = fdone_r;

endmodule
